// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that writes a framed byte stream into the
// byte-addressed instruction memory and holds the CPU in reset until a frame
// loads with a good checksum.
//
// Frame: LEN[7:0], LEN[15:8], LEN[23:16], LEN[31:24], LEN payload bytes, CSUM.
// CSUM is the XOR of all payload bytes. Payload bytes are stored in arrival
// order at BASE_ADDR + i, so instructions are little-endian in memory.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 3200,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] len_q, idx_q;
  logic [7:0]  xor_q;
  logic [1:0]  hcnt_q;
  logic        in_ready_q, cpu_hold_q, err_q, done_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

  logic        acc;
  logic        arm;
  logic [31:0] len_shift;

  // A byte is consumed only when the loader itself advertised ready.
  assign acc       = in_valid_i & in_ready_q;
  // start is only honoured from a resting state; mid-frame it is ignored.
  assign arm       = start_i & ((state_q == S_IDLE) | (state_q == S_DONE) |
                                (state_q == S_ERR));
  // LEN arrives LSB first, so each byte enters at the top and shifts down.
  assign len_shift = {in_data_i, len_q[31:8]};

  // Next-state decode for the frame parser.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (arm) state_d = S_HDR;
      S_HDR: if (acc && hcnt_q == 2'd3) begin
        if (len_shift == 32'd0)                 state_d = S_CSUM;
        else if (len_shift > 32'(MEM_BYTES))    state_d = S_ERR;
        else                                    state_d = S_DATA;
      end
      S_DATA: if (acc && idx_q == len_q - 32'd1) state_d = S_CSUM;
      S_CSUM: if (acc) state_d = (in_data_i == xor_q) ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs follow the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      hcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_HDR) | (state_d == S_DATA) | (state_d == S_CSUM);
      cpu_hold_q <= (state_d != S_DONE);
      err_q      <= (state_d == S_ERR);
      done_q     <= (state_d == S_DONE) & (state_q != S_DONE);
      mem_we_q   <= 1'b0;

      if (arm) begin
        idx_q  <= '0;
        xor_q  <= '0;
        hcnt_q <= '0;
      end

      if (acc) begin
        unique case (state_q)
          S_HDR: begin
            len_q  <= len_shift;
            hcnt_q <= hcnt_q + 2'd1;
          end
          S_DATA: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= BASE_ADDR + idx_q;
            mem_wdata_q <= in_data_i;
            xor_q       <= xor_q ^ in_data_i;
            idx_q       <= idx_q + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign cpu_hold_o  = cpu_hold_q;
  assign err_o       = err_q;
  assign done_o      = done_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
